// File: rtl/store_controller.sv
// Write-back sequencer: walks an output tile row by row from the accumulator
// bank onto the shared memory interface and reports completion.
module store_controller #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              can_store,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_C_stride,
    input  logic [SIZE_W-1:0] msize,
    input  logic [SIZE_W-1:0] nsize,
    input  logic              mem_ready,
    output logic              gen_addr_store,
    output logic [ADDR_W-1:0] next_row_addr_store,
    output logic              interface_en_store,
    output logic [SIZE_W-1:0] interface_control_store,
    output logic              interface_rdwr_store,
    output logic              accum_rd_en,
    output logic [SIZE_W-1:0] accum_row,
    output logic              done_store,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state;
    logic [SIZE_W-1:0] row;
    logic [SIZE_W-1:0] msize_q;
    logic [SIZE_W-1:0] nsize_q;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] stride_q;
    logic              last_row;
    logic [ADDR_W-1:0] addr_step;

    // msize_q is never zero while in WRITE, so the subtraction cannot underflow there.
    assign last_row  = (row == msize_q - 1'b1);
    assign addr_step = addr + stride_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            row      <= '0;
            msize_q  <= '0;
            nsize_q  <= '0;
            addr     <= '0;
            stride_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_store) begin
                        msize_q  <= msize;
                        nsize_q  <= nsize;
                        stride_q <= tile_C_stride;
                        addr     <= tile_C_addr;
                        row      <= '0;
                        state    <= (msize == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        row <= row + 1'b1;
                        if (last_row) state <= IDLE;
                        else          addr  <= addr_step;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Address load and completion are combinational so they line up with the accepted write.
    always_comb begin
        gen_addr_store          = 1'b0;
        next_row_addr_store     = '0;
        interface_en_store      = 1'b0;
        interface_control_store = '0;
        interface_rdwr_store    = 1'b0;
        accum_rd_en             = 1'b0;
        accum_row               = '0;
        done_store              = 1'b0;
        busy                    = (state != IDLE);
        case (state)
            IDLE: begin
                if (can_store) begin
                    gen_addr_store      = 1'b1;
                    next_row_addr_store = tile_C_addr;
                end
            end
            WRITE: begin
                interface_en_store      = 1'b1;
                interface_rdwr_store    = 1'b1;
                interface_control_store = nsize_q;
                accum_row               = row;
                if (mem_ready) begin
                    accum_rd_en = 1'b1;
                    if (last_row) begin
                        done_store = 1'b1;
                    end else begin
                        gen_addr_store      = 1'b1;
                        next_row_addr_store = addr_step;
                    end
                end
            end
            DONE:    done_store = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/store_controller.md
# store_controller

Sequences the write-back of a finished output tile from the accumulator bank to memory through the shared memory interface. Load_Ex_controller raises `can_store` once its compute pass ends. This block then walks the tile row by row: it pops one accumulator row, issues the write on the interface and generates the next row address. It reports completion on `done_store`. Its `*_store` outputs feed Load_Ex_controller, which muxes them onto the interface while in its STORE state.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of tile base, stride and row address.
- `SIZE_W`, 5, width of tile size fields and row counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-low; one clock, reset is asynchronous and active-low.
- `can_store`  in  1  store request level from Load_Ex_controller; sampled only in IDLE.
- `tile_C_addr`  in  ADDR_W  base address of output tile row 0; sampled on start.
- `tile_C_stride`  in  ADDR_W  byte distance between consecutive output rows; sampled on start.
- `msize`  in  SIZE_W  number of rows to store; sampled on start.
- `nsize`  in  SIZE_W  elements per row; sampled on start.
- `mem_ready`  in  1  interface accepts the write presented this cycle.
- `gen_addr_store`  out  1  load `next_row_addr_store` into the address generator.
- `next_row_addr_store`  out  ADDR_W  address of the row to be written next.
- `interface_en_store`  out  1  write request valid.
- `interface_control_store`  out  SIZE_W  transfer length; equals latched nsize.
- `interface_rdwr_store`  out  1  1 = write; high whenever `interface_en_store` is high.
- `accum_rd_en`  out  1  pop current row from accumulator; one pulse per accepted write.
- `accum_row`  out  SIZE_W  index of row currently presented.
- `done_store`  out  1  single-cycle completion pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
States: IDLE, WRITE, DONE.

IDLE
- All outputs 0.
- On `can_store`=1:
  - latch base, stride, msize and nsize;
  - clear the row counter;
  - set the internal address register to `tile_C_addr`;
  - drive `gen_addr_store`=1 and `next_row_addr_store`=`tile_C_addr` combinationally in this cycle.
- If latched msize is 0, go to DONE; otherwise go to WRITE.

WRITE
- Drive `interface_en_store`=1, `interface_rdwr_store`=1, `interface_control_store`=nsize and `accum_row`=row.
- On an accepted write (`mem_ready`=1):
  - pulse `accum_rd_en`;
  - increment row.
- If the accepted row is not the last (row ≠ msize-1):
  - addr ← addr + stride (mod 2^ADDR_W);
  - drive `gen_addr_store`=1 with `next_row_addr_store`=addr + stride in the same cycle.
- If the accepted row is the last:
  - `done_store`=1 combinationally in that same cycle, with no `gen_addr_store`;
  - go to IDLE.
- While `mem_ready`=0, hold every output and register; no pop and no address step.

DONE
- Used only for msize=0.
- `done_store`=1 for one cycle with no interface activity, then go to IDLE.

Other rules:
- `can_store` outside IDLE is ignored. Size and address inputs may change freely after the start cycle.
- Address arithmetic is unsigned and wraps modulo 2^ADDR_W. Stride 0 is legal: every row is written to base.
- msize=31 is the largest tile. The row counter never needs to exceed 31.

## Timing
- Reset (`rst`=0): state goes to IDLE, counters and address clear, all outputs 0. This is immediate and asynchronous, including mid-WRITE; the partial tile is discarded and `done_store` is not issued.
- Start cycle S (IDLE, `can_store`=1): `gen_addr_store` pulses. The first write is presented at S+1.
- With `mem_ready` tied high, row i is accepted at S+1+i and `done_store` pulses at S+msize. Total tile latency is msize+1 cycles.
- Each cycle of `mem_ready`=0 adds exactly one cycle.
- `done_store` lasts exactly one cycle. It coincides with the last write's `interface_en_store` (Load_Ex_controller forwards both in that cycle).
- Back-to-back restart: the earliest new start is the cycle after `done_store`, if `can_store` is high there.

## Test plan
- Basic store: base=0x1000, stride=0x40, msize=4, nsize=8, `mem_ready`=1 → gen addresses 0x1000, 0x1040, 0x1080, 0x10C0; 4 `accum_rd_en` pulses; `done_store` at S+4; control=8 and rdwr=1 on every write.
- Backpressure: msize=3, `mem_ready` low on cycles S+2 and S+3 → row 1 held for 2 cycles with no extra pops; `done_store` at S+5.
- Boundaries:
  - msize=0 → `done_store` at S+1 with no `interface_en_store`;
  - msize=1 → single write and `done_store` at S+1;
  - base=0xFFFFFFC0, stride=0x40, msize=2 → second address 0x00000000.
- Reset mid-WRITE: assert `rst`=0 after row 1 of 4 → all outputs 0 immediately with no `done_store`. After release, a new start with msize=2 completes normally.
- Ignored requests and restart: hold `can_store` high throughout a msize=3 store → no restart before `done_store`, then a new start in the following cycle re-latches the new base.
